// File: rtl/stream_pkg.sv
// Shared encodings for the two-source stream arbiter: source select values
// and the BURST parameter literals.
package stream_pkg;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    localparam logic [23:0] BURST_YES = "yes";
    localparam logic [23:0] BURST_NO  = "no";

endpackage

// File: rtl/rr_grant.sv
// Two-way round-robin grant with last-granted (rr) state and, when
// STREAM_ARBITER_LOCK_EN is defined, a packet lock held until iLast is accepted.
module rr_grant
    import stream_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_accept0,
    input  logic i_accept1,
`ifdef STREAM_ARBITER_LOCK_EN
    input  logic i_last0,
    input  logic i_last1,
`endif
    output logic o_grant0,
    output logic o_grant1
);

    logic r_rr;
`ifdef STREAM_ARBITER_LOCK_EN
    logic r_lock;
    logic r_lockSrc;
`endif

    // A locked source owns the grant outright; otherwise contention goes to
    // the source that was not granted last.
    always_comb begin
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
`ifdef STREAM_ARBITER_LOCK_EN
        if (r_lock) begin
            o_grant0 = i_valid0 & (r_lockSrc == SRC_0);
            o_grant1 = i_valid1 & (r_lockSrc == SRC_1);
        end else
`endif
        if (i_valid0 & i_valid1) begin
            o_grant0 = (r_rr != SRC_0);
            o_grant1 = (r_rr != SRC_1);
        end else begin
            o_grant0 = i_valid0;
            o_grant1 = i_valid1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr      <= SRC_1;
`ifdef STREAM_ARBITER_LOCK_EN
            r_lock    <= 1'b0;
            r_lockSrc <= SRC_0;
`endif
        end else if (i_accept0) begin
            r_rr      <= SRC_0;
`ifdef STREAM_ARBITER_LOCK_EN
            r_lock    <= ~i_last0;
            r_lockSrc <= SRC_0;
`endif
        end else if (i_accept1) begin
            r_rr      <= SRC_1;
`ifdef STREAM_ARBITER_LOCK_EN
            r_lock    <= ~i_last1;
            r_lockSrc <= SRC_1;
`endif
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Two-source stream arbiter with a single registered output stage.
// Optional packet locking is enabled by defining STREAM_ARBITER_LOCK_EN.
module stream_arbiter
    import stream_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [23:0] BURST = BURST_YES
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM0,
    input  logic             iValid_AM1,
    output logic             oReady_AM0,
    output logic             oReady_AM1,
    input  logic [WIDTH-1:0] iData_AM0,
    input  logic [WIDTH-1:0] iData_AM1,
`ifdef STREAM_ARBITER_LOCK_EN
    input  logic             iLast_AM0,
    input  logic             iLast_AM1,
    output logic             oLast_BM,
`endif
    output logic             oValid_BM,
    input  logic             iReady_BM,
    output logic [WIDTH-1:0] oData_BM,
    output logic             oSelect_BM
);

    localparam bit IS_HALF = (BURST == BURST_NO);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
`ifdef STREAM_ARBITER_LOCK_EN
    logic             r_last;
`endif

    logic             w_grant0;
    logic             w_grant1;
    logic             w_canAccept;
    logic             w_acc0;
    logic             w_acc1;

    rr_grant u_rr_grant (
        .i_clk     (iCLK),
        .i_rst     (iRST),
        .i_valid0  (iValid_AM0),
        .i_valid1  (iValid_AM1),
        .i_accept0 (w_acc0),
        .i_accept1 (w_acc1),
`ifdef STREAM_ARBITER_LOCK_EN
        .i_last0   (iLast_AM0),
        .i_last1   (iLast_AM1),
`endif
        .o_grant0  (w_grant0),
        .o_grant1  (w_grant1)
    );

    // Half-throughput mode only accepts into an empty register, so a beat
    // always spends a cycle draining before the next one can enter.
    assign w_canAccept = IS_HALF ? ~r_valid : (~r_valid | iReady_BM);
    assign oReady_AM0  = w_grant0 & w_canAccept & ~iRST;
    assign oReady_AM1  = w_grant1 & w_canAccept & ~iRST;
    assign w_acc0      = oReady_AM0 & iValid_AM0;
    assign w_acc1      = oReady_AM1 & iValid_AM1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= SRC_0;
`ifdef STREAM_ARBITER_LOCK_EN
            r_last  <= 1'b0;
`endif
        end else if (w_acc0 | w_acc1) begin
            r_valid <= 1'b1;
            r_data  <= w_acc1 ? iData_AM1 : iData_AM0;
            r_sel   <= w_acc1 ? SRC_1 : SRC_0;
`ifdef STREAM_ARBITER_LOCK_EN
            r_last  <= w_acc1 ? iLast_AM1 : iLast_AM0;
`endif
        end else if (iReady_BM) begin
            r_valid <= 1'b0;
        end
    end

    assign oValid_BM  = r_valid;
    assign oData_BM   = r_data;
    assign oSelect_BM = r_sel;
`ifdef STREAM_ARBITER_LOCK_EN
    assign oLast_BM   = r_last;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter (WIDTH=4): one full-throughput and one
// half-throughput instance share the stimulus; lock test runs with STREAM_ARBITER_LOCK_EN.
module tb_stream_arbiter;
    import stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1, rdy;
    logic [3:0] d0, d1;
    logic       rdy0A, rdy1A, vA, selA;
    logic [3:0] dA;
    logic       rdy0B, rdy1B, vB, selB;
    logic [3:0] dB;
`ifdef STREAM_ARBITER_LOCK_EN
    logic       l0, l1, lastA, lastB;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_arbiter #(.WIDTH(4), .BURST(BURST_YES)) dutA (
        .iCLK(clk), .iRST(rst),
        .iValid_AM0(v0), .iValid_AM1(v1),
        .oReady_AM0(rdy0A), .oReady_AM1(rdy1A),
        .iData_AM0(d0), .iData_AM1(d1),
`ifdef STREAM_ARBITER_LOCK_EN
        .iLast_AM0(l0), .iLast_AM1(l1), .oLast_BM(lastA),
`endif
        .oValid_BM(vA), .iReady_BM(rdy), .oData_BM(dA), .oSelect_BM(selA)
    );

    stream_arbiter #(.WIDTH(4), .BURST(BURST_NO)) dutB (
        .iCLK(clk), .iRST(rst),
        .iValid_AM0(v0), .iValid_AM1(v1),
        .oReady_AM0(rdy0B), .oReady_AM1(rdy1B),
        .iData_AM0(d0), .iData_AM1(d1),
`ifdef STREAM_ARBITER_LOCK_EN
        .iLast_AM0(l0), .iLast_AM1(l1), .oLast_BM(lastB),
`endif
        .oValid_BM(vB), .iReady_BM(rdy), .oData_BM(dB), .oSelect_BM(selB)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'hF; d1 = 4'hE; rdy = 1'b1;
        tick();
        tick();
        #1;
        vectors++; if (vA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", vA); end
        vectors++; if (dA !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", dA); end
        vectors++; if (selA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sel got %b want 0", selA); end
        vectors++; if ({rdy0A, rdy1A} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 00", {rdy0A, rdy1A}); end
        vectors++; if (vB !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid_half got %b want 0", vB); end
    endtask

    task automatic test_round_robin;
        logic [3:0] expD [3] = '{4'hA, 4'hB, 4'hA};
        logic       expS [3] = '{1'b0, 1'b1, 1'b0};
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 4'hA; d1 = 4'hB; rdy = 1'b1;
        #1;
        vectors++; if ({rdy0A, rdy1A} !== 2'b10) begin miscompares++; $display("[TB] FAIL rr_first_grant got %b want 10", {rdy0A, rdy1A}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ({vA, selA, dA} !== {1'b1, expS[i], expD[i]}) begin
                miscompares++; $display("[TB] FAIL rr_beat%0d got v=%b s=%b d=%h want v=1 s=%b d=%h", i, vA, selA, dA, expS[i], expD[i]);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        vectors++; if (vA !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_drain got %b want 0", vA); end
    endtask

    task automatic test_stall;
        v0 = 1'b0; v1 = 1'b1; d1 = 4'h7; rdy = 1'b0;
        #1;
        vectors++; if (rdy1A !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_accept got %b want 1", rdy1A); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({vA, selA, dA, rdy0A, rdy1A} !== {1'b1, 1'b1, 4'h7, 1'b0, 1'b0}) begin
                miscompares++; $display("[TB] FAIL stall_hold%0d got v=%b s=%b d=%h r=%b%b want v=1 s=1 d=7 r=00", i, vA, selA, dA, rdy0A, rdy1A);
            end
            tick();
        end
        v1 = 1'b0; rdy = 1'b1;
        tick();
        vectors++; if (vA !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain got %b want 0", vA); end
    endtask

    task automatic test_half;
        rst = 1'b1;
        tick();
        rst = 1'b0; v0 = 1'b1; d0 = 4'h3; v1 = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (rdy0B !== ((i % 2) == 0)) begin miscompares++; $display("[TB] FAIL half_ready%0d got %b want %b", i, rdy0B, ((i % 2) == 0)); end
            vectors++; if (rdy0A !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready%0d got %b want 1", i, rdy0A); end
            tick();
            vectors++; if (vB !== ((i % 2) == 0)) begin miscompares++; $display("[TB] FAIL half_valid%0d got %b want %b", i, vB, ((i % 2) == 0)); end
        end
        v0 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        v0 = 1'b1; d0 = 4'h5; v1 = 1'b0; rdy = 1'b0;
        tick();
        v0 = 1'b0;
        #1;
        vectors++; if ({vA, dA} !== {1'b1, 4'h5}) begin miscompares++; $display("[TB] FAIL mid_hold got v=%b d=%h want v=1 d=5", vA, dA); end
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
        #1;
        vectors++; if ({rdy0A, rdy1A, rdy0B, rdy1B} !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_ready_in_reset got %b want 0000", {rdy0A, rdy1A, rdy0B, rdy1B}); end
        tick();
        vectors++; if ({vA, dA} !== {1'b0, 4'h0}) begin miscompares++; $display("[TB] FAIL mid_flush got v=%b d=%h want v=0 d=0", vA, dA); end
        rst = 1'b0;
        #1;
        vectors++; if ({rdy0A, rdy1A} !== 2'b10) begin miscompares++; $display("[TB] FAIL mid_first_grant got %b want 10", {rdy0A, rdy1A}); end
        rdy = 1'b1;
        tick();
        vectors++; if ({vA, selA, dA} !== {1'b1, 1'b0, 4'h5}) begin miscompares++; $display("[TB] FAIL mid_first_beat got v=%b s=%b d=%h want v=1 s=0 d=5", vA, selA, dA); end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

`ifdef STREAM_ARBITER_LOCK_EN
    task automatic test_lock;
        logic [3:0] expD [4] = '{4'h1, 4'h2, 4'h3, 4'h9};
        logic       expS [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       expL [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        tick();
        rst = 1'b0; v0 = 1'b1; d0 = 4'h1; l0 = 1'b0; v1 = 1'b1; d1 = 4'h9; l1 = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if ({vA, selA, dA, lastA} !== {1'b1, expS[i], expD[i], expL[i]}) begin
                miscompares++; $display("[TB] FAIL lock_beat%0d got s=%b d=%h l=%b want s=%b d=%h l=%b", i, selA, dA, lastA, expS[i], expD[i], expL[i]);
            end
            if (i == 0) d0 = 4'h2;
            if (i == 1) begin d0 = 4'h3; l0 = 1'b1; end
            if (i == 2) v0 = 1'b0;
        end
        v1 = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random;
        logic [4:0] expQ [$];
        logic [4:0] got;
        logic [2:0] cnt0 = 3'd0;
        logic [2:0] cnt1 = 3'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 204; cyc++) begin
            if (cyc < 200) begin
                v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
            end else begin
                v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
            end
            d0 = {1'b0, cnt0}; d1 = {1'b1, cnt1};
            #1;
            vectors++; if (rdy0A & rdy1A) begin miscompares++; $display("[TB] FAIL rand_both_ready cycle %0d got 11 want not 11", cyc); end
            if (vA & rdy) begin
                got = {selA, dA};
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++; $display("[TB] FAIL rand_extra_beat cycle %0d got %h want none", cyc, got);
                end else if (got !== expQ[0]) begin
                    miscompares++; $display("[TB] FAIL rand_order cycle %0d got %h want %h", cyc, got, expQ[0]);
                    void'(expQ.pop_front());
                end else begin
                    void'(expQ.pop_front());
                end
            end
            if (rdy0A & v0) begin expQ.push_back({1'b0, d0}); cnt0++; end
            if (rdy1A & v1) begin expQ.push_back({1'b1, d1}); cnt1++; end
            tick();
        end
        vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL rand_lost_beats got %0d pending want 0", expQ.size()); end
        vectors++; if (vA !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_final_valid got %b want 0", vA); end
    endtask

    initial begin
`ifdef STREAM_ARBITER_LOCK_EN
        l0 = 1'b1; l1 = 1'b1;
`endif
        test_reset();
        test_round_robin();
        test_stall();
        test_half();
        test_reset_mid();
`ifdef STREAM_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of every stream, in bits.
REQ-002 Parameter BURST, default "yes": "yes" gives full throughput (1 beat/cycle); "no" gives half throughput (at most 1 beat per 2 cycles).
REQ-003 iCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 iRST  in  1  reset, synchronous, active-high.
REQ-005 iValid_AM0 / iValid_AM1  in  1  requester 0/1 beat valid.
REQ-006 oReady_AM0 / oReady_AM1  out  1  requester 0/1 beat accepted this cycle.
REQ-007 iData_AM0 / iData_AM1  in  WIDTH  requester 0/1 payload.
REQ-008 oValid_BM  out  1  merged-stream beat valid.
REQ-009 iReady_BM  in  1  consumer ready.
REQ-010 oData_BM  out  WIDTH  merged payload.
REQ-011 oSelect_BM  out  1  source index of the current oData_BM beat.

Function
REQ-012 Transfer on any port occurs only when its valid and ready are both high in the same cycle.
REQ-013 Grant is combinational from current valids: only one valid -> that source; both valid -> source != rr; neither -> no grant.
REQ-014 rr (last-granted source) updates to the accepted source on every input transfer; otherwise it holds.
REQ-015 Output stage is one register: accepted beat appears on oData_BM/oSelect_BM/oValid_BM the next cycle (latency 1).
REQ-016 BURST="yes": oReady_AMx = grant_x & (~oValid_BM | iReady_BM); a simultaneous output drain and input accept SHALL keep oValid_BM high with the new beat.
REQ-017 BURST="no": oReady_AMx = grant_x & ~oValid_BM.
REQ-018 Stall (oValid_BM=1, iReady_BM=0): oData_BM and oSelect_BM SHALL hold stable and both oReady_AMx SHALL be 0.
REQ-019 Drain with no new accept clears oValid_BM next cycle; oData_BM is don't-care while oValid_BM=0.
REQ-020 Both oReady_AMx SHALL never be high in the same cycle.

Reset
REQ-021 While iRST=1 at a clock edge: oValid_BM<=0, oData_BM<=0, oSelect_BM<=0, rr<=1 (source 0 wins first contention), lock cleared.
REQ-022 Reset mid-operation discards the buffered beat; oReady_AMx SHALL be 0 during any cycle in which iRST=1.

Configuration
REQ-023 Macro STREAM_ARBITER_LOCK_EN defined: adds ports iLast_AM0/iLast_AM1 (in, 1) and oLast_BM (out, 1; registered alongside data, reset 0).
REQ-024 With lock: accepting a beat with iLast=0 locks grant to that source until a beat with iLast=1 from it is accepted; the other source's valid is ignored meanwhile.
REQ-025 Without the macro: those ports are absent and every beat is arbitrated independently per REQ-013.

Structure
REQ-026 Shared package stream_pkg holds SRC_0/SRC_1 select encodings and BURST literals "yes"/"no".
REQ-027 Sub-module rr_grant (2-way round-robin grant plus rr/lock state); output register stays in stream_arbiter.
REQ-028 Target size: 120-400 lines of RTL.

Verification (WIDTH=4)
REQ-029 Both valid after reset, data0=0xA, data1=0xB, iReady_BM=1 -> outputs 0xA/sel0, then 0xB/sel1, then 0xA/sel0, on consecutive cycles (BURST="yes").
REQ-030 Only AM1 valid with 0x7, iReady_BM=0 for 3 cycles -> oValid_BM=1, 0x7/sel1 held stable, both readies 0; iReady_BM=1 -> drained, oValid_BM=0 next cycle.
REQ-031 BURST="no", AM0 continuously valid, iReady_BM=1 -> oReady_AM0 alternates 1,0,1,0; one beat per 2 cycles.
REQ-032 iRST asserted while oValid_BM=1 holding 0x5 -> next cycle oValid_BM=0, oData_BM=0; first post-reset contention grants source 0.
REQ-033 LOCK_EN: AM0 sends 0x1,0x2,0x3 (last on 0x3) while AM1 valid with 0x9 -> output 0x1,0x2,0x3 then 0x9.
REQ-034 Random valid/ready toggling, 200 cycles -> no beat lost or duplicated, per-source order preserved, REQ-020 never violated.
